// File: rtl/pkg_ooo.sv
// ----------------------------------------------------------------------------
// pkg_ooo
// Shared constants for the out-of-order core's physical register file and
// its writeback path, plus a helper for addressing one requester's field
// inside a flat packed port.
// ----------------------------------------------------------------------------
package pkg_ooo;

    localparam int PRF_TAG_W  = 6;
    localparam int PRF_DATA_W = 32;
    localparam int PRF_DEPTH  = 64;

    // Width of the encoded requester index (supports up to 8 requesters).
    localparam int GRANT_ID_W = 3;

    // LSB position of requester idx's field in a port packed as
    // {req[N-1], ..., req[1], req[0]} with each field width bits wide.
    function automatic int unsigned req_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority selector. Starting at ptr and moving
// upward with wrap-around, the first asserted valid bit wins.
//
// Ports:
//   valid     [NUM_REQ-1:0]  request lines
//   ptr       [IDX_W-1:0]    highest-priority requester this cycle (< NUM_REQ)
//   grant     [NUM_REQ-1:0]  one-hot grant, zero when nothing is valid
//   grant_idx [IDX_W-1:0]    encoded index of the granted requester
//   grant_any                some requester is granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int cand_s;

    // Walk the requesters in priority order from ptr; first valid one wins.
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        grant_any = 1'b0;
        cand_s    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s = int'(ptr) + off;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            // Compare against the loop index so every select stays constant.
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == cand_s) && !grant_any && valid[j]) begin
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                    grant_any = 1'b1;
                end else begin
                    grant_any = grant_any;
                end
            end
        end
    end

endmodule

// File: rtl/prf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// prf_wb_arbiter
// Shares the single write port of the physical register file between
// NUM_REQ writeback requesters. The round-robin winner is registered and
// driven onto the PRF write port and the wakeup tag broadcast together.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   flush          pipeline flush: blocks grants, kills the next writeback
//   req_valid      per-requester writeback valid
//   req_waddr      per-requester destination tag, requester i at [i*TAG_W +: TAG_W]
//   req_data       per-requester result, packed like req_waddr
//   req_ready      one-hot grant (combinational)
//   prf_we/prf_waddr/prf_din   registered PRF write port
//   wb_tag_valid/wb_tag        wakeup broadcast, mirrors prf_we/prf_waddr
//   grant_id       requester index behind the current prf_we
// ----------------------------------------------------------------------------
module prf_wb_arbiter
    import pkg_ooo::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = PRF_DATA_W,
    parameter int TAG_W   = PRF_TAG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_waddr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      prf_we,
    output logic [TAG_W-1:0]          prf_waddr,
    output logic [DATA_W-1:0]         prf_din,
    output logic                      wb_tag_valid,
    output logic [TAG_W-1:0]          wb_tag,
    output logic [GRANT_ID_W-1:0]     grant_id
);

    logic [GRANT_ID_W-1:0] rr_ptr_r;
    logic                  prf_we_r;
    logic [TAG_W-1:0]      prf_waddr_r;
    logic [DATA_W-1:0]     prf_din_r;
    logic [GRANT_ID_W-1:0] grant_id_r;

    logic [NUM_REQ-1:0]    grant_s;
    logic [GRANT_ID_W-1:0] grant_idx_s;
    logic                  grant_any_s;
    logic [TAG_W-1:0]      sel_waddr_s;
    logic [DATA_W-1:0]     sel_data_s;
    logic [GRANT_ID_W-1:0] rr_ptr_next_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_ID_W)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Grants are withheld during reset and flush so no handshake can complete.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (rst_n && !flush) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_waddr_s = {TAG_W{1'b0}};
        sel_data_s  = {DATA_W{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_s[j]) begin
                sel_waddr_s = req_waddr[req_lsb(j, TAG_W) +: TAG_W];
                sel_data_s  = req_data[req_lsb(j, DATA_W) +: DATA_W];
            end else begin
                sel_waddr_s = sel_waddr_s;
            end
        end
    end

    // Pointer moves to just past the winner, wrapping at NUM_REQ-1.
    always_comb begin
        rr_ptr_next_s = {GRANT_ID_W{1'b0}};
        if (grant_idx_s == GRANT_ID_W'(NUM_REQ - 1)) begin
            rr_ptr_next_s = {GRANT_ID_W{1'b0}};
        end else begin
            rr_ptr_next_s = grant_idx_s + GRANT_ID_W'(1);
        end
    end

    // Output register and round-robin pointer; reset beats flush beats grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prf_we_r    <= 1'b0;
            prf_waddr_r <= {TAG_W{1'b0}};
            prf_din_r   <= {DATA_W{1'b0}};
            grant_id_r  <= {GRANT_ID_W{1'b0}};
            rr_ptr_r    <= {GRANT_ID_W{1'b0}};
        end else if (flush) begin
            prf_we_r    <= 1'b0;
        end else if (grant_any_s) begin
            prf_we_r    <= 1'b1;
            prf_waddr_r <= sel_waddr_s;
            prf_din_r   <= sel_data_s;
            grant_id_r  <= grant_idx_s;
            rr_ptr_r    <= rr_ptr_next_s;
        end else begin
            // Address/data hold so the write port does not toggle when idle.
            prf_we_r    <= 1'b0;
        end
    end

    assign prf_we       = prf_we_r;
    assign prf_waddr    = prf_waddr_r;
    assign prf_din      = prf_din_r;
    assign wb_tag_valid = prf_we_r;
    assign wb_tag       = prf_waddr_r;
    assign grant_id     = grant_id_r;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_prf_wb_arbiter
// Directed self-checking bench for prf_wb_arbiter with three requesters.
// Inputs change 1 time unit after posedge; registered outputs are sampled
// at the same point, req_ready 1 time unit later.
// ----------------------------------------------------------------------------
module tb_prf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  v;
    logic [5:0]  a [3];
    logic [31:0] d [3];

    logic [2:0]  req_valid;
    logic [17:0] req_waddr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        prf_we;
    logic [5:0]  prf_waddr;
    logic [31:0] prf_din;
    logic        wb_tag_valid;
    logic [5:0]  wb_tag;
    logic [2:0]  grant_id;

    int n_vec = 0;
    int n_err = 0;

    assign req_valid = v;
    assign req_waddr = {a[2], a[1], a[0]};
    assign req_data  = {d[2], d[1], d[0]};

    // {we, waddr, din, grant_id, tag_valid, tag}
    wire [48:0] obs_o = {prf_we, prf_waddr, prf_din, grant_id, wb_tag_valid, wb_tag};

    prf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .TAG_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_waddr    (req_waddr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .prf_we       (prf_we),
        .prf_waddr    (prf_waddr),
        .prf_din      (prf_din),
        .wb_tag_valid (wb_tag_valid),
        .wb_tag       (wb_tag),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester hold rule: a pending request must stay valid and unchanged.
    logic [2:0]  pend = 3'b000;
    logic [5:0]  pa [3];
    logic [31:0] pd [3];
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && pend[i]) begin
                n_vec++;
                if (!req_valid[i] || a[i] !== pa[i] || d[i] !== pd[i]) begin
                    n_err++;
                    $display("FAIL hold_rule req%0d: valid=%b addr=%0d data=%h, required addr=%0d data=%h",
                             i, req_valid[i], a[i], d[i], pa[i], pd[i]);
                end
            end
            pend[i] = rst_n && req_valid[i] && !req_ready[i];
            pa[i]   = a[i];
            pd[i]   = d[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [48:0] e;
        rst_n = 1'b0; flush = 1'b0; v = 3'b111;
        a[0] = 6'd10; a[1] = 6'd20; a[2] = 6'd30;
        d[0] = 32'h1111_0000; d[1] = 32'h2222_0000; d[2] = 32'h3333_0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (req_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready c%0d: got %b want 000", c, req_ready); end
            e = {1'b0, 6'd0, 32'd0, 3'd0, 1'b0, 6'd0};
            n_vec++;
            if (obs_o !== e) begin n_err++; $display("FAIL rst_outputs c%0d: got %h want %h", c, obs_o, e); end
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL rst_first_grant: got %b want 001", req_ready); end
        tick();
        e = {1'b1, 6'd10, 32'h1111_0000, 3'd0, 1'b1, 6'd10};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rst_wb0: got %h want %h", obs_o, e); end
        v[0] = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL rst_ready1: got %b want 010", req_ready); end
        tick();
        e = {1'b1, 6'd20, 32'h2222_0000, 3'd1, 1'b1, 6'd20};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rst_wb1: got %h want %h", obs_o, e); end
        v[1] = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL rst_ready2: got %b want 100", req_ready); end
        tick();
        e = {1'b1, 6'd30, 32'h3333_0000, 3'd2, 1'b1, 6'd30};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rst_wb2: got %h want %h", obs_o, e); end
        v[2] = 1'b0;
        tick();
        // Idle: write enable drops, address/data/id hold.
        e = {1'b0, 6'd30, 32'h3333_0000, 3'd2, 1'b0, 6'd30};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL idle_hold: got %h want %h", obs_o, e); end
    endtask

    task automatic test_round_robin;
        logic [48:0] e;
        logic [2:0]  r;
        int          k;
        v = 3'b111;
        a[0] = 6'd1; a[1] = 6'd2; a[2] = 6'd3;
        d[0] = 32'hA000_0000; d[1] = 32'hB000_0000; d[2] = 32'hC000_0000;
        for (int c = 0; c < 8; c++) begin
            k = c % 3;
            r = 3'b001 << k;
            #1;
            n_vec++;
            if (req_ready !== r) begin n_err++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, r); end
            e = {1'b1, a[k], d[k], 3'(k), 1'b1, a[k]};
            tick();
            n_vec++;
            if (obs_o !== e) begin n_err++; $display("FAIL rr_wb c%0d: got %h want %h", c, obs_o, e); end
            a[k] = a[k] + 6'd8;
            d[k] = d[k] + 32'h0101_0101;
            if (c >= 5) v[k] = 1'b0;
        end
        #1;
        n_vec++;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL rr_drain_ready: got %b want 000", req_ready); end
        tick();
        n_vec++;
        if (prf_we !== 1'b0) begin n_err++; $display("FAIL rr_idle_we: got %b want 0", prf_we); end
    endtask

    task automatic test_single;
        logic [48:0] e;
        a[1] = 6'd17; d[1] = 32'hDEAD_BEEF; v = 3'b010;
        #1;
        n_vec++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want 010", req_ready); end
        tick();
        e = {1'b1, 6'd17, 32'hDEAD_BEEF, 3'd1, 1'b1, 6'd17};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL single_wb: got %h want %h", obs_o, e); end
        v = 3'b000;
        #1;
        n_vec++;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL single_noreq: got %b want 000", req_ready); end
        tick();
        e = {1'b0, 6'd17, 32'hDEAD_BEEF, 3'd1, 1'b0, 6'd17};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL single_idle: got %h want %h", obs_o, e); end
    endtask

    task automatic test_wrap;
        logic [48:0] e;
        // rr_ptr is 2 here; req0 and req2 both target tag 42.
        a[0] = 6'd42; a[2] = 6'd42;
        d[0] = 32'hA0A0_A0A0; d[2] = 32'hC2C2_C2C2; v = 3'b101;
        #1;
        n_vec++;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL wrap_ready_a: got %b want 100", req_ready); end
        tick();
        e = {1'b1, 6'd42, 32'hC2C2_C2C2, 3'd2, 1'b1, 6'd42};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL wrap_wb_a: got %h want %h", obs_o, e); end
        d[2] = 32'hC3C3_C3C3;
        #1;
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL wrap_ready_b: got %b want 001", req_ready); end
        tick();
        e = {1'b1, 6'd42, 32'hA0A0_A0A0, 3'd0, 1'b1, 6'd42};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL wrap_wb_b: got %h want %h", obs_o, e); end
        d[0] = 32'hA1A1_A1A1;
        #1;
        n_vec++;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL wrap_ready_c: got %b want 100", req_ready); end
        tick();
        e = {1'b1, 6'd42, 32'hC3C3_C3C3, 3'd2, 1'b1, 6'd42};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL wrap_wb_c: got %h want %h", obs_o, e); end
        v[2] = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL wrap_ready_d: got %b want 001", req_ready); end
        tick();
        e = {1'b1, 6'd42, 32'hA1A1_A1A1, 3'd0, 1'b1, 6'd42};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL wrap_wb_d: got %h want %h", obs_o, e); end
        v = 3'b000;
        tick();
    endtask

    task automatic test_flush;
        logic [48:0] e;
        // rr_ptr is 1 here. Cycle N: grant to req1.
        a[1] = 6'd7; d[1] = 32'h0BAD_F00D; v = 3'b010;
        #1;
        n_vec++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL flush_grant1: got %b want 010", req_ready); end
        tick();
        // Cycle N+1: req1's writeback is out, flush up, req0 waiting.
        e = {1'b1, 6'd7, 32'h0BAD_F00D, 3'd1, 1'b1, 6'd7};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL flush_inflight: got %h want %h", obs_o, e); end
        a[0] = 6'd3; d[0] = 32'h3333_3333; v = 3'b001; flush = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL flush_ready: got %b want 000", req_ready); end
        tick();
        e = {1'b0, 6'd7, 32'h0BAD_F00D, 3'd1, 1'b0, 6'd7};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL flush_kill: got %h want %h", obs_o, e); end
        flush = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL flush_after_ready: got %b want 001", req_ready); end
        tick();
        e = {1'b1, 6'd3, 32'h3333_3333, 3'd0, 1'b1, 6'd3};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL flush_after_wb: got %h want %h", obs_o, e); end
        v = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid;
        logic [48:0] e;
        // rr_ptr is 1 here; handshake with req0 moves it to 1 again.
        a[0] = 6'd50; d[0] = 32'h5050_5050; v = 3'b001;
        #1;
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL rmid_grant: got %b want 001", req_ready); end
        tick();
        e = {1'b1, 6'd50, 32'h5050_5050, 3'd0, 1'b1, 6'd50};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rmid_wb: got %h want %h", obs_o, e); end
        rst_n = 1'b0;
        a[1] = 6'd51; d[1] = 32'h5151_5151; a[2] = 6'd52; d[2] = 32'h5252_5252; v = 3'b110;
        #1;
        n_vec++;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL rmid_ready: got %b want 000", req_ready); end
        tick();
        e = {1'b0, 6'd0, 32'd0, 3'd0, 1'b0, 6'd0};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rmid_cleared: got %h want %h", obs_o, e); end
        rst_n = 1'b1;
        a[0] = 6'd53; d[0] = 32'h5353_5353; v = 3'b111;
        #1;
        // Pointer back at 0 even though the last grant left it at 1.
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL rmid_ptr0: got %b want 001", req_ready); end
        tick();
        e = {1'b1, 6'd53, 32'h5353_5353, 3'd0, 1'b1, 6'd53};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rmid_wb0: got %h want %h", obs_o, e); end
        v[0] = 1'b0;
        tick();
        e = {1'b1, 6'd51, 32'h5151_5151, 3'd1, 1'b1, 6'd51};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rmid_wb1: got %h want %h", obs_o, e); end
        v[1] = 1'b0;
        tick();
        e = {1'b1, 6'd52, 32'h5252_5252, 3'd2, 1'b1, 6'd52};
        n_vec++;
        if (obs_o !== e) begin n_err++; $display("FAIL rmid_wb2: got %h want %h", obs_o, e); end
        v = 3'b000;
        tick();
        n_vec++;
        if (prf_we !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got %b want 0", prf_we); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
